// File: rtl/spw_light_link_monitor.sv
// spw_light_link_monitor: SpaceWire link state/error monitor with stuck-link timeout,
// saturating error and RUN-entry counters, Avalon-MM register file and level IRQ.
module spw_light_link_monitor #(
  parameter int TIMEOUT_CYCLES = 6400,
  parameter int ERR_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        started,
  input  logic        connecting,
  input  logic        running,
  input  logic        errdisc,
  input  logic        errpar,
  input  logic        erresc,
  input  logic        errcred,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        connecting_out,
  output logic        irq
);
  typedef enum logic [2:0] {IDLE = 3'd0, STARTED = 3'd1, CONNECTING = 3'd2, RUN = 3'd3, STUCK = 3'd4} state_t;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state_q, state_d, dec;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [3:0][ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [15:0] run_cnt_q, run_cnt_d;
  logic timeout_seen_q, timeout_seen_d, err_seen_q, err_seen_d;
  logic [1:0] irq_mask_q, irq_mask_d;
  logic irq_q, irq_d, connecting_out_q;
  logic [31:0] readdata_q, readdata_d;
  logic [3:0] pulse;
  logic wr0, wr1, wr2, wr3, run_entry;
  logic unused_wd;
  assign unused_wd = ^{writedata[31:4], writedata[2]};
  assign pulse = {errcred, erresc, errpar, errdisc};
  assign wr0 = write && address == 2'd0;
  assign wr1 = write && address == 2'd1;
  assign wr2 = write && address == 2'd2;
  assign wr3 = write && address == 2'd3;
  always_comb begin
    dec = running ? RUN : connecting ? CONNECTING : started ? STARTED : IDLE;
    state_d = (state_q == STUCK && connecting && !running) ||
              (state_q == CONNECTING && dec == CONNECTING && tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) ? STUCK : dec;
    tmo_cnt_d = state_q == CONNECTING ? tmo_cnt_q + 1'b1 : '0;
    timeout_seen_d = (wr0 && writedata[3]) ? 1'b0 : timeout_seen_q | (state_d == STUCK && state_q != STUCK);
    for (int i = 0; i < 4; i++)
      err_cnt_d[i] = wr1 ? '0 : (pulse[i] && err_cnt_q[i] != '1) ? err_cnt_q[i] + 1'b1 : err_cnt_q[i];
    err_seen_d = wr1 ? 1'b0 : err_seen_q | (|pulse);
    run_entry = state_d == RUN && state_q != RUN;
    run_cnt_d = wr2 ? '0 : (run_entry && run_cnt_q != 16'hFFFF) ? run_cnt_q + 1'b1 : run_cnt_q;
    irq_mask_d = wr3 ? writedata[1:0] : irq_mask_q;
    irq_d = (irq_mask_q[0] & err_seen_q) | (irq_mask_q[1] & timeout_seen_q);
    // Read mux uses pre-write register values; writes become visible one clk later.
    readdata_d = address == 2'd0 ? {28'b0, timeout_seen_q, state_q} :
                 address == 2'd1 ? {8'(err_cnt_q[3]), 8'(err_cnt_q[2]), 8'(err_cnt_q[1]), 8'(err_cnt_q[0])} :
                 address == 2'd2 ? {16'b0, run_cnt_q} : {30'b0, irq_mask_q};
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tmo_cnt_q <= '0;
      err_cnt_q <= '0;
      run_cnt_q <= '0;
      timeout_seen_q <= 1'b0;
      err_seen_q <= 1'b0;
      irq_mask_q <= '0;
      irq_q <= 1'b0;
      connecting_out_q <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      err_cnt_q <= err_cnt_d;
      run_cnt_q <= run_cnt_d;
      timeout_seen_q <= timeout_seen_d;
      err_seen_q <= err_seen_d;
      irq_mask_q <= irq_mask_d;
      irq_q <= irq_d;
      connecting_out_q <= connecting;
      readdata_q <= readdata_d;
    end
  end
  assign readdata = readdata_q;
  assign connecting_out = connecting_out_q;
  assign irq = irq_q;
endmodule

// File: doc/spw_light_link_monitor.md
SPW_LIGHT_LINK_MONITOR -- requirements
Module: spw_light_link_monitor

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 6400, cycles allowed in CONNECTING before declaring a stuck link.
REQ-002 SHALL have parameter ERR_W, default 8, width of each saturating error counter.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have ports started, connecting, running  input  1 each  link FSM level flags from the SpaceWire core.
REQ-006 SHALL have ports errdisc, errpar, erresc, errcred  input  1 each  single-cycle error pulses from the SpaceWire core.
REQ-007 SHALL have port address  input  2  Avalon-MM slave word address.
REQ-008 SHALL have ports write  input  1 and writedata  input  32  Avalon-MM write strobe and data.
REQ-009 SHALL have port readdata  output  32  registered Avalon-MM read data.
REQ-010 SHALL have port connecting_out  output  1  registered connecting level, fed to the connecting PIO in_port.
REQ-011 SHALL have port irq  output  1  level interrupt.

Function
REQ-012 SHALL decode link state each cycle with priority running > connecting > started > none into FSM states IDLE, STARTED, CONNECTING, RUN, STUCK.
REQ-013 SHALL enter STUCK when the timeout counter reaches TIMEOUT_CYCLES-1 while in CONNECTING; STUCK SHALL persist while connecting stays high and running stays low.
REQ-014 SHALL exit STUCK to RUN on running=1, or to the decoded state when connecting=0.
REQ-015 Timeout counter SHALL clear on every cycle not in CONNECTING and SHALL increment by 1 each cycle in CONNECTING, so that re-entering CONNECTING restarts the count.
REQ-016 SHALL set sticky flag timeout_seen on the cycle STUCK is entered; it SHALL be cleared only by reset or by a write to address 0 with writedata[3]=1.
REQ-017 connecting_out SHALL equal the connecting input delayed by exactly one clk.
REQ-018 SHALL keep four ERR_W-bit counters (disc, par, esc, cred), each incrementing by 1 per pulse of its input and saturating at all-ones (no wrap).
REQ-019 SHALL set sticky flag err_seen on any error pulse; a write to address 1 (any data) SHALL clear all four counters and err_seen.
REQ-020 If a clear and an increment occur in the same cycle, the clear SHALL win and the counter SHALL read 0.
REQ-021 SHALL count RUN entries (transition from any non-RUN state into RUN) in a 16-bit counter saturating at 0xFFFF; a write to address 2 SHALL clear it, with clear winning over increment.
REQ-022 Register map: addr0 = {28'b0, timeout_seen, state[2:0]} with IDLE=0, STARTED=1, CONNECTING=2, RUN=3, STUCK=4; addr1 = {cred, esc, par, disc} packed LSB-first, each zero-extended to 8 bits; addr2 = {16'b0, run_count}; addr3 = {30'b0, irq_mask[1:0]}.
REQ-023 irq_mask SHALL be writable at address 3 from writedata[1:0]; bit0 enables err_seen, bit1 enables timeout_seen.
REQ-024 irq SHALL be registered and SHALL equal (irq_mask[0] & err_seen) | (irq_mask[1] & timeout_seen), lagging the flags by one clk.
REQ-025 readdata SHALL update every clk from the currently selected address, independent of any read strobe, giving a read latency of 1 clk.
REQ-026 readdata SHALL reflect register contents from before a same-cycle write; the written value SHALL appear one clk later.

Reset
REQ-027 On reset_n=0, the block SHALL immediately force the FSM to IDLE and clear the timeout counter, all error counters, run_count, timeout_seen, err_seen and irq_mask, and drive readdata=0, connecting_out=0 and irq=0, independent of clk.
REQ-028 Reset asserted mid-CONNECTING SHALL discard the partial timeout count; after release, the full TIMEOUT_CYCLES SHALL be required to reach STUCK.

Verification
REQ-029 Hold connecting=1 for TIMEOUT_CYCLES+5 cycles (TIMEOUT_CYCLES=16) -> state 4 at addr0, bit3=1; with irq_mask=2'b10, irq=1.
REQ-030 Hold connecting=1 for 10 cycles, then 0, then 1 again for 10 cycles (TIMEOUT_CYCLES=16) -> never STUCK; timeout_seen stays 0.
REQ-031 Apply 300 errpar pulses -> addr1[15:8]=0xFF; a write to addr1 in the same cycle as a pulse -> counters read 0.
REQ-032 Toggle running 0->1 three times -> addr2=3; connecting_out follows connecting with a 1-cycle lag.
REQ-033 Assert reset_n=0 mid-STUCK with irq=1 -> readdata=0, irq=0, connecting_out=0 without any clk edge.
